// File: rtl/sm_adc_spi_responder.sv
`default_nettype none
// ============================================================================
// | Module   : sm_adc_spi_responder                                          |
// | Purpose  : Responder for an 8-channel, 12-bit serial ADC interface with   |
// |            ADC128S022-style framing. Oversamples the master's SCK, CS_N  |
// |            and DIN on clk and returns preloaded per-channel samples on   |
// |            DOUT, so the ADC path can be closed without a physical ADC.   |
// | Ports    : clk, rst_n     - system clock (>= 8x SCK), sync active-low rst|
// |            ch_data        - channel c sample at [c*DATA_W +: DATA_W]     |
// |            adc_sck/cs_n/din - master serial interface (async to clk)     |
// |            adc_dout       - serial data back to the master               |
// |            adc_dout_oe    - high while the frame is active (tri-state)   |
// |            frame_done     - one-clk pulse on the 16th SCK rising edge    |
// |            cur_ch         - channel of the current or last frame         |
// | Options  : `define ADC_RESP_FRAME_ERR_EN adds frame_err (sticky) and     |
// |            err_cnt (saturating abort count).                             |
// | Revision : 1.0 - initial release                                         |
// ============================================================================
module sm_adc_spi_responder #(
    parameter int DATA_W      = 12,
    parameter int NUM_CH      = 8,
    parameter int SYNC_STAGES = 2   // must be 2 or more
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_CH*DATA_W-1:0] ch_data,
    input  logic                     adc_sck,
    input  logic                     adc_cs_n,
    input  logic                     adc_din,
    output logic                     adc_dout,
    output logic                     adc_dout_oe,
    output logic                     frame_done,
`ifdef ADC_RESP_FRAME_ERR_EN
    output logic                     frame_err,
    output logic [7:0]               err_cnt,
`endif
    output logic [2:0]               cur_ch
);

    localparam int         c_FRAME_SCK = 16;
    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_ACTIVE = 2'd1;
    localparam logic [1:0] c_ST_HOLD   = 2'd2;

    logic [SYNC_STAGES-1:0] r_sck_sync;
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_din_sync;
    logic                   r_sck_prev;
    logic                   r_cs_prev;
    logic [1:0]             r_state;
    logic [4:0]             r_rise_cnt;
    logic [4:0]             r_fall_cnt;
    logic [2:0]             r_addr;
    logic [2:0]             r_next_ch;
    logic [c_FRAME_SCK-1:0] r_shift;

    logic              w_sck;
    logic              w_cs_n;
    logic              w_din;
    logic              w_sck_rise;
    logic              w_sck_fall;
    logic              w_cs_rise;
    logic              w_cs_fall;
    logic [DATA_W-1:0] w_sample;
    logic [2:0]        w_addr_ch;

    assign w_sck      = r_sck_sync[SYNC_STAGES-1];
    assign w_cs_n     = r_cs_sync[SYNC_STAGES-1];
    assign w_din      = r_din_sync[SYNC_STAGES-1];
    assign w_sck_rise = w_sck & ~r_sck_prev;
    assign w_sck_fall = ~w_sck & r_sck_prev;
    assign w_cs_rise  = w_cs_n & ~r_cs_prev;
    assign w_cs_fall  = ~w_cs_n & r_cs_prev;

    // r_next_ch is always below NUM_CH, so this select stays in range.
    assign w_sample  = ch_data[int'(r_next_ch)*DATA_W +: DATA_W];
    // Out-of-range addresses fold back onto the implemented channels.
    assign w_addr_ch = 3'(int'(r_addr) % NUM_CH);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sck_sync  <= '0;
            r_cs_sync   <= '1;
            r_din_sync  <= '0;
            r_sck_prev  <= 1'b0;
            r_cs_prev   <= 1'b1;
            r_state     <= c_ST_IDLE;
            r_rise_cnt  <= '0;
            r_fall_cnt  <= '0;
            r_addr      <= '0;
            r_next_ch   <= '0;
            r_shift     <= '0;
            adc_dout    <= 1'b0;
            adc_dout_oe <= 1'b0;
            frame_done  <= 1'b0;
            cur_ch      <= '0;
        end else begin
            r_sck_sync <= {r_sck_sync[SYNC_STAGES-2:0], adc_sck};
            r_cs_sync  <= {r_cs_sync[SYNC_STAGES-2:0], adc_cs_n};
            r_din_sync <= {r_din_sync[SYNC_STAGES-2:0], adc_din};
            r_sck_prev <= w_sck;
            r_cs_prev  <= w_cs_n;
            frame_done <= 1'b0;

            case (r_state)
                c_ST_IDLE: begin
                    adc_dout    <= 1'b0;
                    adc_dout_oe <= 1'b0;
                    if (w_cs_fall) begin
                        // Sample is frozen here; later ch_data changes do not
                        // reach this frame. The leading zero drives out now.
                        cur_ch      <= r_next_ch;
                        r_shift     <= c_FRAME_SCK'(w_sample);
                        r_rise_cnt  <= '0;
                        r_fall_cnt  <= '0;
                        adc_dout_oe <= 1'b1;
                        adc_dout    <= 1'b0;
                        r_state     <= c_ST_ACTIVE;
                    end
                end

                c_ST_ACTIVE: begin
                    // CS edges win over a coincident SCK edge.
                    if (w_cs_rise) begin
                        if (r_rise_cnt >= 5'd5) begin
                            r_next_ch <= w_addr_ch;
                        end
                        adc_dout    <= 1'b0;
                        adc_dout_oe <= 1'b0;
                        r_state     <= c_ST_IDLE;
                    end else if (w_sck_rise) begin
                        r_rise_cnt <= r_rise_cnt + 5'd1;
                        case (r_rise_cnt)
                            5'd2:  r_addr[2] <= w_din;
                            5'd3:  r_addr[1] <= w_din;
                            5'd4:  r_addr[0] <= w_din;
                            5'd15: begin
                                r_next_ch  <= w_addr_ch;
                                frame_done <= 1'b1;
                                r_state    <= c_ST_HOLD;
                            end
                            default: ;
                        endcase
                    end else if (w_sck_fall) begin
                        // Each falling edge presents the next frame bit; the
                        // CS-fall zero was bit 15, so falls 1..15 give 14..0.
                        if (r_fall_cnt < 5'd15) begin
                            r_fall_cnt <= r_fall_cnt + 5'd1;
                            r_shift    <= {r_shift[c_FRAME_SCK-2:0], 1'b0};
                            adc_dout   <= r_shift[c_FRAME_SCK-2];
                        end
                    end
                end

                c_ST_HOLD: begin
                    // LSB stays on the line; extra SCK edges are ignored.
                    if (w_cs_rise) begin
                        adc_dout    <= 1'b0;
                        adc_dout_oe <= 1'b0;
                        r_state     <= c_ST_IDLE;
                    end
                end

                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

`ifdef ADC_RESP_FRAME_ERR_EN
    logic w_abort;
    logic w_stray_sck;

    assign w_abort     = (r_state == c_ST_ACTIVE) && w_cs_rise;
    assign w_stray_sck = w_cs_n && (w_sck_rise || w_sck_fall);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_err <= 1'b0;
            err_cnt   <= '0;
        end else begin
            if (w_abort || w_stray_sck) begin
                frame_err <= 1'b1;
            end
            if (w_abort && (err_cnt != 8'hFF)) begin
                err_cnt <= err_cnt + 8'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_sm_adc_spi_responder.sv
`default_nettype none
// ============================================================================
// | Module   : tb_sm_adc_spi_responder                                       |
// | Purpose  : Self-checking bench for sm_adc_spi_responder. Acts as the ADC |
// |            master (SCK idle low, 16 clk per SCK period) and compares the |
// |            returned frames against a frame-level reference model.        |
// | Revision : 1.0 - initial release                                         |
// ============================================================================
module tb_sm_adc_spi_responder;

    localparam int DATA_W      = 12;
    localparam int NUM_CH      = 8;
    localparam int SYNC_STAGES = 2;
    localparam int HALF        = 8;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic [NUM_CH*DATA_W-1:0] ch_data;
    logic                     adc_sck;
    logic                     adc_cs_n;
    logic                     adc_din;
    logic                     adc_dout;
    logic                     adc_dout_oe;
    logic                     frame_done;
    logic [2:0]               cur_ch;
`ifdef ADC_RESP_FRAME_ERR_EN
    logic                     frame_err;
    logic [7:0]               err_cnt;
`endif

    sm_adc_spi_responder #(
        .DATA_W      (DATA_W),
        .NUM_CH      (NUM_CH),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ch_data     (ch_data),
        .adc_sck     (adc_sck),
        .adc_cs_n    (adc_cs_n),
        .adc_din     (adc_din),
        .adc_dout    (adc_dout),
        .adc_dout_oe (adc_dout_oe),
        .frame_done  (frame_done),
`ifdef ADC_RESP_FRAME_ERR_EN
        .frame_err   (frame_err),
        .err_cnt     (err_cnt),
`endif
        .cur_ch      (cur_ch)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          done_cnt = 0;
    int          frame_base;
    int          oe_bad;
    int          done_by17;
    logic [15:0] got_bits;
    logic [1:0]  got_hold;
    int          m_next_ch;
    int          m_aborts;

    always @(negedge clk) begin
        if (frame_done === 1'b1) done_cnt++;
    end

    typedef struct {
        logic [2:0]  addr;
        logic [15:0] exp_bits;
        int          exp_ch;
    } vec_t;

    vec_t vecs [3];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_ch(input int c, input logic [DATA_W-1:0] v);
        ch_data[c*DATA_W +: DATA_W] = v;
    endtask

    // Reference: the channel for the next frame is the captured address
    // (mod NUM_CH) once the frame completes or is aborted after 5 rises.
    function automatic int model_next(input int cur, input logic [2:0] addr, input int abort_rises);
        if (abort_rises < 0 || abort_rises >= 5) return int'(addr) % NUM_CH;
        return cur;
    endfunction

    // abort_rises < 0: full frame of nper periods; otherwise raise CS after
    // that many rising edges. chg_at: overwrite channel 0 after that rise.
    task automatic run_frame(input logic [2:0] addr, input int nper, input int abort_rises,
                             input int chg_at, input logic [DATA_W-1:0] chg_val);
        got_bits   = '0;
        got_hold   = '0;
        oe_bad     = 0;
        done_by17  = 0;
        frame_base = done_cnt;
        adc_sck    = 1'b0;
        adc_din    = 1'b0;
        adc_cs_n   = 1'b0;
        for (int k = 1; k <= nper; k++) begin
            repeat (HALF) @(negedge clk);
            if (abort_rises == k - 1) break;
            if (k <= 16) got_bits[16-k] = adc_dout;
            else         got_hold[k-17] = adc_dout;
            if (k == 17) done_by17 = done_cnt - frame_base;
            if (adc_dout_oe !== 1'b1) oe_bad++;
            adc_sck = 1'b1;
            repeat (HALF) @(negedge clk);
            if (k == chg_at) set_ch(0, chg_val);
            adc_sck = 1'b0;
            case (k)
                2:       adc_din = addr[2];
                3:       adc_din = addr[1];
                4:       adc_din = addr[0];
                default: adc_din = 1'($urandom);
            endcase
        end
        if (abort_rises < 0) repeat (HALF) @(negedge clk);
        adc_cs_n = 1'b1;
    endtask

    // Called right after CS rises; total CS-high window is one SCK period.
    task automatic finish_frame(input string name, input logic [15:0] exp_bits, input int exp_ch,
                                input int exp_done, input bit complete);
        repeat (SYNC_STAGES) @(posedge clk);
        #1;
        chk({name, "_oe_before_sync"}, 32'(adc_dout_oe), 32'd1);
        @(posedge clk);
        #1;
        chk({name, "_oe_off"}, 32'(adc_dout_oe), 32'd0);
        chk({name, "_dout_off"}, 32'(adc_dout), 32'd0);
        repeat (4) @(negedge clk);
        chk({name, "_frame_done"}, 32'(done_cnt - frame_base), 32'(exp_done));
        chk({name, "_cur_ch"}, 32'(cur_ch), 32'(exp_ch));
        if (complete) begin
            chk({name, "_bits"}, 32'(got_bits), 32'(exp_bits));
            chk({name, "_oe_during"}, 32'(oe_bad), 32'd0);
        end
        repeat (2*HALF - 8) @(negedge clk);
    endtask

    initial begin
        rst_n    = 1'b0;
        adc_sck  = 1'b0;
        adc_cs_n = 1'b1;
        adc_din  = 1'b0;
        ch_data  = '0;
        for (int c = 0; c < NUM_CH; c++) set_ch(c, 12'($urandom));
        set_ch(0, 12'hA5C);
        set_ch(2, 12'h3F1);
        set_ch(7, 12'h7E2);
        m_next_ch = 0;
        m_aborts  = 0;

        vecs[0] = '{addr: 3'b010, exp_bits: 16'h0A5C, exp_ch: 0};
        vecs[1] = '{addr: 3'b111, exp_bits: 16'h03F1, exp_ch: 2};
        vecs[2] = '{addr: 3'b000, exp_bits: 16'h07E2, exp_ch: 7};

        repeat (5) @(negedge clk);
        chk("rst_dout", 32'(adc_dout), 32'd0);
        chk("rst_oe", 32'(adc_dout_oe), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        chk("rst_cur_ch", 32'(cur_ch), 32'd0);
`ifdef ADC_RESP_FRAME_ERR_EN
        chk("rst_frame_err", 32'(frame_err), 32'd0);
        chk("rst_err_cnt", 32'(err_cnt), 32'd0);
`endif
        rst_n = 1'b1;
        repeat (2*HALF) @(negedge clk);

        // Directed frames from the vector table.
        for (int i = 0; i < 3; i++) begin
            run_frame(vecs[i].addr, 16, -1, 0, '0);
            finish_frame($sformatf("vec%0d", i), vecs[i].exp_bits, vecs[i].exp_ch, 1, 1'b1);
            m_next_ch = model_next(m_next_ch, vecs[i].addr, -1);
        end

        // Sample frozen at CS fall: channel 0 rewritten after the 6th rise.
        set_ch(0, 12'h123);
        run_frame(3'b100, 16, -1, 6, 12'hFFF);
        finish_frame("snapshot", 16'h0123, 0, 1, 1'b1);
        m_next_ch = model_next(m_next_ch, 3'b100, -1);

        // Abort after 3 rises: address incomplete, channel stays 4.
        run_frame(3'b001, 16, 3, 0, '0);
        finish_frame("abort3", 16'h0000, 4, 0, 1'b0);
        m_next_ch = model_next(m_next_ch, 3'b001, 3);
        m_aborts++;
`ifdef ADC_RESP_FRAME_ERR_EN
        chk("abort3_frame_err", 32'(frame_err), 32'd1);
        chk("abort3_err_cnt", 32'(err_cnt), 32'd1);
`endif
        run_frame(3'b000, 16, -1, 0, '0);
        finish_frame("after_abort", {4'b0, ch_data[4*DATA_W +: DATA_W]}, 4, 1, 1'b1);
        m_next_ch = model_next(m_next_ch, 3'b000, -1);

        // 18 SCK periods in one CS window: one pulse, LSB held.
        set_ch(0, 12'h001);
        run_frame(3'b110, 18, -1, 0, '0);
        chk("long_done_by_rise17", 32'(done_by17), 32'd1);
        chk("long_hold_bits", 32'(got_hold), 32'd3);
        finish_frame("long", 16'h0001, 0, 1, 1'b1);
        m_next_ch = model_next(m_next_ch, 3'b110, -1);

        // Randomized back-to-back frames against the model.
        for (int i = 0; i < 24; i++) begin
            logic [2:0]        a;
            int                ab;
            int                np;
            int                ec;
            logic [DATA_W-1:0] es;
            for (int c = 0; c < NUM_CH; c++) set_ch(c, 12'($urandom));
            a  = 3'($urandom);
            ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 15)) : -1;
            np = (ab < 0) ? int'($urandom_range(16, 18)) : 16;
            ec = m_next_ch;
            es = ch_data[ec*DATA_W +: DATA_W];
            run_frame(a, np, ab, 0, '0);
            finish_frame($sformatf("rnd%0d", i), {4'b0, es}, ec, (ab < 0) ? 1 : 0, ab < 0);
            m_next_ch = model_next(m_next_ch, a, ab);
            if (ab >= 0) m_aborts++;
        end
`ifdef ADC_RESP_FRAME_ERR_EN
        chk("final_err_cnt", 32'(err_cnt), 32'((m_aborts > 255) ? 255 : m_aborts));
        chk("final_frame_err", 32'(frame_err), 32'd1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
